// File: rtl/sub_seq32.sv
// Sequential nibble-serial subtractor: computes a - b one 4-bit slice per clock,
// LSB first, then reports diff with borrow/overflow/zero/negative flags.
module sub_seq32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_chain;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [3:0]       w_a_nibs [NIB];
    logic [3:0]       w_b_nibs [NIB];
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_slice;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;
    logic             w_ovf;

    // Slice selection and diff update are per-nibble; only the active nibble changes.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign w_a_nibs[gi] = r_a[4*gi +: 4];
        assign w_b_nibs[gi] = r_b[4*gi +: 4];
        assign w_diff_next[4*gi +: 4] = (r_cnt == CW'(gi)) ? w_slice[3:0]
                                                            : r_diff[4*gi +: 4];
    end

    assign w_a_nib = w_a_nibs[r_cnt];
    assign w_b_nib = w_b_nibs[r_cnt];
    assign w_slice = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_chain};
    assign w_last  = (r_cnt == CW'(NIB - 1));
    assign w_ovf   = (r_a[MSB] ^ r_b[MSB]) & (w_diff_next[MSB] ^ r_a[MSB]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_chain  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= '0;
                        r_chain <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_diff  <= w_diff_next;
                    r_chain <= w_slice[4];
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_borrow <= w_slice[4];
                        r_ovf    <= w_ovf;
                        r_zero   <= (w_diff_next == '0);
                        r_neg    <= w_diff_next[MSB];
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign diff        = r_diff;
    assign borrow      = r_borrow;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
    assign neg         = r_neg;

endmodule
